masked_zero_bank: RTL
=====================

Name: masked_zero_bank

Overview:
- Multi-channel, buffered generator of fresh Boolean sharings of zero, consumed by masked multipliers and refresh gadgets in the AES datapath.
- Per channel, turns fresh randomness into NUM_SHARES shares whose XOR is zero, and queues the results in a DEPTH-entry FIFO.
- Randomness input and sharing output each use a valid/ready handshake, so the PRNG and consumers may stall independently.
- Supports 2..8 shares, any channel count, and a test mode that emits all-zero shares.

Parameters:
- NUM_SHARES, 2, shares per sharing; legal 2..8, otherwise elaboration $fatal.
- BIT_WIDTH, 2, bits per share.
- NUM_CHANNELS, 1, independent zero-sharings produced per transfer.
- DEPTH, 2, FIFO entries; power of two, at least 1.
- COUNT_WIDTH, 16, width of the delivered-sharing counter.
- Derived NUM_NEEDED: 1 if NUM_SHARES==2; 2 if NUM_SHARES==3; otherwise NUM_SHARES.

Ports:
- in_clock  input  1  clock; all state on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_random  input  NUM_CHANNELS*NUM_NEEDED*BIT_WIDTH  fresh randomness; packed [channel][index][bit].
- in_random_valid  input  1  in_random holds fresh randomness.
- out_random_ready  output  1  block accepts in_random this cycle.
- in_zero_mode  input  1  test mode; entries pushed while high are all-zero shares.
- out_random  output  NUM_CHANNELS*NUM_SHARES*BIT_WIDTH  zero-sharings; packed [channel][share][bit].
- out_valid  output  1  out_random holds a FIFO head entry.
- in_ready  input  1  consumer takes out_random this cycle.
- out_count  output  COUNT_WIDTH  number of sharings delivered (pops), saturating.

Behaviour:
- Clock and reset: single clock in_clock; reset in_reset is synchronous, active-high.
- Sharing per channel c, with r_k = in_random[c][k]:
  - N=2: (r0, r0).
  - N=3: (r0, r1, r0^r1).
  - N>=4: share_i = r_i ^ r_{(i+1) mod N}.
- Invariant: XOR over all shares of every channel is 0 for every popped entry, in every mode.
- Push: occurs when in_random_valid && out_random_ready. The computed sharing, or all zeros if in_zero_mode is high that cycle, is written at the tail.
- Randomness is consumed on every push, including in zero mode.
- Pop: occurs when out_valid && in_ready; the head advances.
- out_random_ready = (occupancy < DEPTH), driven from registered state only.
  - There is no same-cycle pass-through when full: a pop in a full cycle frees space only in the next cycle.
- Push and pop in the same cycle with occupancy in 1..DEPTH-1: occupancy unchanged; data order preserved.
- Push and pop in the same cycle with occupancy 0: only the push takes effect, because out_valid is low.
- Latency: randomness accepted in cycle t is visible with out_valid=1 in cycle t+1 if the FIFO was empty. Output is registered, with no combinational path from in_random to out_random.
- out_valid = (occupancy != 0).
- out_random = head entry when out_valid; all zeros when empty. Stale shares are never exposed.
- Read/write pointers wrap modulo DEPTH. Occupancy is tracked with a counter of width clog2(DEPTH)+1.
- DEPTH==1 degenerates to a single register with full/empty flag.
- out_count increments by 1 on each pop and saturates at 2^COUNT_WIDTH-1, with no wrap.
- Reset: occupancy 0, pointers 0, out_valid 0, out_random 0, out_count 0, out_random_ready 1 in the cycle after reset deasserts.
  - Reset during traffic discards all queued entries; handshakes in the reset cycle are ignored.
  - FIFO storage contents need not be cleared, but must not be observable.
- in_zero_mode only affects entries pushed while it is high. Queued entries keep their mode.

Test Plan:
- Reset, NUM_SHARES=2, BIT_WIDTH=2: push in_random=2'b10 with in_ready=1 -> next cycle out_valid=1, out_random={10,10}; following cycle out_count=1, out_valid=0, out_random=0.
- NUM_SHARES=4, BIT_WIDTH=4, randomness r=(1,2,4,8) -> shares (3,6,C,9); XOR = 0. Randomised 1000 pushes, NUM_SHARES 3..8 -> XOR of every popped channel is always 0.
- DEPTH=2, in_ready=0, three consecutive valid pushes -> first two accepted, out_random_ready=0 on the third; raising in_ready for one cycle -> ready returns the next cycle; pops come out in push order.
- Simultaneous push/pop at occupancy 1 for 10 cycles -> occupancy stays 1; outputs equal inputs delayed by one pop.
- in_zero_mode=1 on the second of three pushes -> popped entries nonzero, all-zero, nonzero; out_count=3.
- Reset asserted with 2 entries queued and in_random_valid=1 -> next cycle out_valid=0, out_count=0, out_random_ready=1; no entry ever reappears.
- COUNT_WIDTH=2, 5 pops -> out_count holds at 3.

Source files
------------

// File: rtl/masked_zero_bank.sv
// Buffered, multi-channel generator of Boolean sharings of zero for masked AES gadgets.
// Fresh randomness is expanded into NUM_SHARES shares per channel and queued in a DEPTH-entry FIFO.
module masked_zero_bank #(
  parameter int NUM_SHARES   = 2,
  parameter int BIT_WIDTH    = 2,
  parameter int NUM_CHANNELS = 1,
  parameter int DEPTH        = 2,
  parameter int COUNT_WIDTH  = 16,
  localparam int NUM_NEEDED  = (NUM_SHARES == 2) ? 1 : ((NUM_SHARES == 3) ? 2 : NUM_SHARES),
  localparam int RAND_W      = NUM_CHANNELS * NUM_NEEDED * BIT_WIDTH,
  localparam int SHARE_W     = NUM_CHANNELS * NUM_SHARES * BIT_WIDTH
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic [RAND_W-1:0]      in_random,
  input  logic                   in_random_valid,
  output logic                   out_random_ready,
  input  logic                   in_zero_mode,
  output logic [SHARE_W-1:0]     out_random,
  output logic                   out_valid,
  input  logic                   in_ready,
  output logic [COUNT_WIDTH-1:0] out_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (NUM_SHARES < 2 || NUM_SHARES > 8) begin : g_bad_shares
    $fatal(1, "masked_zero_bank: NUM_SHARES must be in 2..8");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "masked_zero_bank: DEPTH must be a power of two >= 1");
  end

  logic [SHARE_W-1:0]     w_share;
  logic [SHARE_W-1:0]     w_wdata;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_not_empty;
  logic [OCC_W-1:0]       r_occ;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [SHARE_W-1:0]     r_mem [DEPTH];

  // Share i of channel c; every randomness word appears in exactly two shares, so XOR is zero.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_sh
      if (NUM_SHARES == 2) begin : g_n2
        assign w_share[(c*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH] =
          in_random[(c*NUM_NEEDED)*BIT_WIDTH +: BIT_WIDTH];
      end else if (NUM_SHARES == 3) begin : g_n3
        if (i < 2) begin : g_direct
          assign w_share[(c*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH] =
            in_random[(c*NUM_NEEDED+i)*BIT_WIDTH +: BIT_WIDTH];
        end else begin : g_sum
          assign w_share[(c*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH] =
            in_random[(c*NUM_NEEDED)*BIT_WIDTH +: BIT_WIDTH] ^
            in_random[(c*NUM_NEEDED+1)*BIT_WIDTH +: BIT_WIDTH];
        end
      end else begin : g_ring
        assign w_share[(c*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH] =
          in_random[(c*NUM_NEEDED+i)*BIT_WIDTH +: BIT_WIDTH] ^
          in_random[(c*NUM_NEEDED+((i+1)%NUM_SHARES))*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Both ports: a transfer happens exactly on a cycle where valid and ready are both high.
  // Ready depends only on registered occupancy, so a pop never frees space in the same cycle.
  assign w_not_empty      = (r_occ != '0);
  assign out_random_ready = (r_occ < OCC_FULL);
  assign out_valid        = w_not_empty;
  assign w_push           = in_random_valid && out_random_ready && !in_reset;
  assign w_pop            = w_not_empty && in_ready && !in_reset;
  assign w_wdata          = in_zero_mode ? '0 : w_share;
  assign out_random       = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign out_count        = r_count;

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_occ    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_pop && (r_count != '1)) r_count <= r_count + 1'b1;
    end
  end

  // Storage is never cleared; the empty mask on out_random hides stale entries.
  always_ff @(posedge in_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

endmodule
